ram_write_arbiter: RTL and testbench

Shares the single write port of the ram block between two write clients: client 0 is terminal_stream, client 1 is the planned screen clear/scroll engine. Clients get fair round-robin access, and one transaction is in flight at a time. Address, data and mask are latched at grant, so the ram sees stable fields for the whole transaction. The block sits between the clients and the ram wr_* port in the top level and runs in the 108 MHz clk domain.

---
 rtl/ram_write_arbiter.sv | 104 ++++++++++
 tb/tb_ram_write_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter sharing the ram write port between two write clients.
// Fields are captured at grant; one transaction is in flight at a time.
module ram_write_arbiter #(
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MASK_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  c0_wr_request,
   input  logic [ADDR_WIDTH-1:0] c0_wr_address,
   input  logic [DATA_WIDTH-1:0] c0_wr_data,
   input  logic [MASK_WIDTH-1:0] c0_wr_mask,
   output logic                  c0_wr_done,
   input  logic                  c1_wr_request,
   input  logic [ADDR_WIDTH-1:0] c1_wr_address,
   input  logic [DATA_WIDTH-1:0] c1_wr_data,
   input  logic [MASK_WIDTH-1:0] c1_wr_mask,
   output logic                  c1_wr_done,
   output logic                  ram_wr_request,
   output logic [ADDR_WIDTH-1:0] ram_wr_address,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [MASK_WIDTH-1:0] ram_wr_mask,
   input  logic                  ram_wr_done,
   output logic                  busy,
   output logic                  grant
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic                  r_grant;
   logic                  r_last;
   logic                  r_c0_done;
   logic                  r_c1_done;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [MASK_WIDTH-1:0] r_mask;
   logic                  w_any_req;
   logic                  w_pick;
   logic                  w_take;
   logic                  w_finish;

   assign w_any_req = c0_wr_request | c1_wr_request;
   // On a tie the client that was not served last wins.
   assign w_pick    = (c0_wr_request && c1_wr_request) ? ~r_last : c1_wr_request;
   assign w_take    = (r_state == StIdle) && w_any_req;
   assign w_finish  = (r_state == StGrant) && ram_wr_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_any_req) w_state_next = StGrant;
         StGrant: if (ram_wr_done) w_state_next = StGap;
         StGap:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant   <= 1'b0;
         r_last    <= 1'b1;
         r_c0_done <= 1'b0;
         r_c1_done <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_mask    <= '0;
      end else begin
         r_c0_done <= w_finish && !r_grant;
         r_c1_done <= w_finish && r_grant;
         if (w_take) begin
            r_grant <= w_pick;
            r_addr  <= w_pick ? c1_wr_address : c0_wr_address;
            r_data  <= w_pick ? c1_wr_data    : c0_wr_data;
            r_mask  <= w_pick ? c1_wr_mask    : c0_wr_mask;
         end
         if (w_finish) begin
            r_last <= r_grant;
         end
      end
   end

   always_comb begin
      ram_wr_request = (r_state == StGrant);
      busy           = (r_state != StIdle);
      grant          = r_grant;
      ram_wr_address = r_addr;
      ram_wr_data    = r_data;
      ram_wr_mask    = r_mask;
      c0_wr_done     = r_c0_done;
      c1_wr_done     = r_c1_done;
   end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter: a table of single transactions plus
// hand-written sequences for contention, field stability, spurious done and reset.
module tb_ram_write_arbiter;

   logic        clk;
   logic        reset;
   logic        c0_wr_request;
   logic [22:0] c0_wr_address;
   logic [31:0] c0_wr_data;
   logic [3:0]  c0_wr_mask;
   logic        c0_wr_done;
   logic        c1_wr_request;
   logic [22:0] c1_wr_address;
   logic [31:0] c1_wr_data;
   logic [3:0]  c1_wr_mask;
   logic        c1_wr_done;
   logic        ram_wr_request;
   logic [22:0] ram_wr_address;
   logic [31:0] ram_wr_data;
   logic [3:0]  ram_wr_mask;
   logic        ram_wr_done;
   logic        busy;
   logic        grant;

   int n_checks = 0;
   int n_errors = 0;

   ram_write_arbiter #(
      .ADDR_WIDTH(23),
      .DATA_WIDTH(32),
      .MASK_WIDTH(4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .c0_wr_request  (c0_wr_request),
      .c0_wr_address  (c0_wr_address),
      .c0_wr_data     (c0_wr_data),
      .c0_wr_mask     (c0_wr_mask),
      .c0_wr_done     (c0_wr_done),
      .c1_wr_request  (c1_wr_request),
      .c1_wr_address  (c1_wr_address),
      .c1_wr_data     (c1_wr_data),
      .c1_wr_mask     (c1_wr_mask),
      .c1_wr_done     (c1_wr_done),
      .ram_wr_request (ram_wr_request),
      .ram_wr_address (ram_wr_address),
      .ram_wr_data    (ram_wr_data),
      .ram_wr_mask    (ram_wr_mask),
      .ram_wr_done    (ram_wr_done),
      .busy           (busy),
      .grant          (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        r0;
      logic        r1;
      logic [22:0] a0;
      logic [31:0] d0;
      logic [3:0]  m0;
      logic [22:0] a1;
      logic [31:0] d1;
      logic [3:0]  m1;
      int          lat;
      logic        eg;
      logic [22:0] ea;
      logic [31:0] ed;
      logic [3:0]  em;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [22:0] f_addr(input int c, input int k);
      return 23'(32'h1000 * (c + 1) + k);
   endfunction

   function automatic logic [31:0] f_data(input int c, input int k);
      return 32'hC0DE0000 + 32'(c * 256) + 32'(k);
   endfunction

   function automatic logic [3:0] f_mask(input int c, input int k);
      return 4'((k + c) % 16);
   endfunction

   task automatic drop_all();
      c0_wr_request = 1'b0;
      c1_wr_request = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int cnt = 0;
      while (!ram_wr_request && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk(name, 64'(ram_wr_request), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      c0_wr_request = v.r0;
      c0_wr_address = v.a0;
      c0_wr_data    = v.d0;
      c0_wr_mask    = v.m0;
      c1_wr_request = v.r1;
      c1_wr_address = v.a1;
      c1_wr_data    = v.d1;
      c1_wr_mask    = v.m1;
      @(negedge clk);
      chk($sformatf("v%0d_req", idx), 64'(ram_wr_request), 64'd1);
      chk($sformatf("v%0d_grant", idx), 64'(grant), 64'(v.eg));
      chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
      chk($sformatf("v%0d_addr", idx), 64'(ram_wr_address), 64'(v.ea));
      chk($sformatf("v%0d_data", idx), 64'(ram_wr_data), 64'(v.ed));
      chk($sformatf("v%0d_mask", idx), 64'(ram_wr_mask), 64'(v.em));
      repeat (v.lat - 1) @(negedge clk);
      chk($sformatf("v%0d_hold", idx), 64'(ram_wr_request), 64'd1);
      ram_wr_done = 1'b1;
      @(negedge clk);
      ram_wr_done = 1'b0;
      chk($sformatf("v%0d_reqdrop", idx), 64'(ram_wr_request), 64'd0);
      chk($sformatf("v%0d_done0", idx), 64'(c0_wr_done), 64'(!v.eg));
      chk($sformatf("v%0d_done1", idx), 64'(c1_wr_done), 64'(v.eg));
      chk($sformatf("v%0d_gapbusy", idx), 64'(busy), 64'd1);
      @(negedge clk);
      chk($sformatf("v%0d_idlebusy", idx), 64'(busy), 64'd0);
      chk($sformatf("v%0d_idlereq", idx), 64'(ram_wr_request), 64'd0);
      chk($sformatf("v%0d_idledone", idx), 64'({c0_wr_done, c1_wr_done}), 64'd0);
      drop_all();
   endtask

   initial begin
      int served0;
      int served1;
      int dones;
      logic exp_g;

      // Fields: r0 r1 a0 d0 m0 a1 d1 m1 lat | grant addr data mask
      vecs[0] = '{1'b1, 1'b0, 23'h000123, 32'hDEADBEEF, 4'hF, 23'h0, 32'h0, 4'h0, 5,
                  1'b0, 23'h000123, 32'hDEADBEEF, 4'hF};
      vecs[1] = '{1'b1, 1'b1, 23'h000200, 32'h11111111, 4'h1, 23'h400200, 32'h22222222, 4'h2,
                  2, 1'b1, 23'h400200, 32'h22222222, 4'h2};
      vecs[2] = '{1'b1, 1'b1, 23'h000300, 32'h33333333, 4'h3, 23'h400300, 32'h44444444, 4'h4,
                  1, 1'b0, 23'h000300, 32'h33333333, 4'h3};
      vecs[3] = '{1'b0, 1'b1, 23'h000000, 32'h0, 4'h0, 23'h7FFFFF, 32'hFFFFFFFF, 4'h8, 3,
                  1'b1, 23'h7FFFFF, 32'hFFFFFFFF, 4'h8};
      vecs[4] = '{1'b0, 1'b1, 23'h000000, 32'h0, 4'h0, 23'h000001, 32'h00000001, 4'h1, 1,
                  1'b1, 23'h000001, 32'h00000001, 4'h1};
      vecs[5] = '{1'b1, 1'b1, 23'h0ABCDE, 32'hA5A5A5A5, 4'h6, 23'h012345, 32'h5A5A5A5A, 4'h9,
                  4, 1'b0, 23'h0ABCDE, 32'hA5A5A5A5, 4'h6};
      vecs[6] = '{1'b1, 1'b0, 23'h7FFFFF, 32'h80000000, 4'hA, 23'h0, 32'h0, 4'h0, 2,
                  1'b0, 23'h7FFFFF, 32'h80000000, 4'hA};
      vecs[7] = '{1'b1, 1'b1, 23'h000777, 32'h77777777, 4'h7, 23'h000888, 32'h88888888, 4'hE,
                  2, 1'b1, 23'h000888, 32'h88888888, 4'hE};

      reset         = 1'b1;
      drop_all();
      c0_wr_address = '0;
      c0_wr_data    = '0;
      c0_wr_mask    = '0;
      c1_wr_address = '0;
      c1_wr_data    = '0;
      c1_wr_mask    = '0;
      ram_wr_done   = 1'b0;
      #1;
      chk("rst_req", 64'(ram_wr_request), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_done", 64'({c0_wr_done, c1_wr_done}), 64'd0);
      chk("rst_fields", 64'({ram_wr_address, ram_wr_mask}), 64'd0);
      chk("rst_data", 64'(ram_wr_data), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Simultaneous first requests, then continuous contention of 6 writes each.
      @(negedge clk);
      served0 = 0;
      served1 = 0;
      dones   = 0;
      exp_g   = 1'b0;
      c0_wr_address = f_addr(0, 0);
      c0_wr_data    = f_data(0, 0);
      c0_wr_mask    = f_mask(0, 0);
      c1_wr_address = f_addr(1, 0);
      c1_wr_data    = f_data(1, 0);
      c1_wr_mask    = f_mask(1, 0);
      c0_wr_request = 1'b1;
      c1_wr_request = 1'b1;
      for (int t = 0; t < 12; t++) begin
         int k;
         k = exp_g ? served1 : served0;
         wait_req($sformatf("cont%0d_req", t));
         chk($sformatf("cont%0d_grant", t), 64'(grant), 64'(exp_g));
         chk($sformatf("cont%0d_addr", t), 64'(ram_wr_address), 64'(f_addr(int'(exp_g), k)));
         chk($sformatf("cont%0d_data", t), 64'(ram_wr_data), 64'(f_data(int'(exp_g), k)));
         chk($sformatf("cont%0d_mask", t), 64'(ram_wr_mask), 64'(f_mask(int'(exp_g), k)));
         @(negedge clk);
         ram_wr_done = 1'b1;
         @(negedge clk);
         ram_wr_done = 1'b0;
         chk($sformatf("cont%0d_done", t), 64'({c1_wr_done, c0_wr_done}),
             exp_g ? 64'd2 : 64'd1);
         if (c0_wr_done || c1_wr_done) dones++;
         @(negedge clk);
         if (!exp_g) begin
            served0++;
            if (served0 < 6) begin
               c0_wr_address = f_addr(0, served0);
               c0_wr_data    = f_data(0, served0);
               c0_wr_mask    = f_mask(0, served0);
            end else begin
               c0_wr_request = 1'b0;
            end
         end else begin
            served1++;
            if (served1 < 6) begin
               c1_wr_address = f_addr(1, served1);
               c1_wr_data    = f_data(1, served1);
               c1_wr_mask    = f_mask(1, served1);
            end else begin
               c1_wr_request = 1'b0;
            end
         end
         exp_g = ~exp_g;
      end
      chk("cont_total_dones", 64'(dones), 64'd12);
      @(negedge clk);
      chk("cont_idle", 64'(busy), 64'd0);

      // Table vectors start from a fresh reset so client 0 wins the first tie.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], i);
      end

      // Spurious done in IDLE produces nothing.
      @(negedge clk);
      ram_wr_done = 1'b1;
      @(negedge clk);
      ram_wr_done = 1'b0;
      chk("spur_done", 64'({c0_wr_done, c1_wr_done}), 64'd0);
      chk("spur_busy", 64'(busy), 64'd0);
      chk("spur_req", 64'(ram_wr_request), 64'd0);
      @(negedge clk);
      chk("spur_done2", 64'({c0_wr_done, c1_wr_done}), 64'd0);

      // Field stability and illegal request drop while granted.
      c1_wr_address = 23'h055555;
      c1_wr_data    = 32'h12345678;
      c1_wr_mask    = 4'h5;
      c1_wr_request = 1'b1;
      @(negedge clk);
      chk("stab_grant", 64'(grant), 64'd1);
      c1_wr_data    = 32'hFFFF0000;
      c1_wr_address = 23'h000000;
      @(negedge clk);
      chk("stab_data", 64'(ram_wr_data), 64'h12345678);
      chk("stab_addr", 64'(ram_wr_address), 64'h055555);
      c1_wr_request = 1'b0;
      @(negedge clk);
      chk("stab_req_held", 64'(ram_wr_request), 64'd1);
      ram_wr_done = 1'b1;
      @(negedge clk);
      ram_wr_done = 1'b0;
      chk("stab_done1", 64'(c1_wr_done), 64'd1);
      chk("stab_done0", 64'(c0_wr_done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("stab_done1_pulse", 64'(c1_wr_done), 64'd0);

      // Reset during GRANT abandons the transaction; pending c1 is served after release.
      c0_wr_address = 23'h000ABC;
      c0_wr_data    = 32'hCAFEF00D;
      c0_wr_mask    = 4'hC;
      c0_wr_request = 1'b1;
      @(negedge clk);
      chk("mrst_grant0", 64'(grant), 64'd0);
      chk("mrst_req", 64'(ram_wr_request), 64'd1);
      reset = 1'b1;
      #1;
      chk("mrst_async_req", 64'(ram_wr_request), 64'd0);
      chk("mrst_async_busy", 64'(busy), 64'd0);
      c0_wr_request = 1'b0;
      c1_wr_address = 23'h000DEF;
      c1_wr_data    = 32'hBEEFCAFE;
      c1_wr_mask    = 4'h3;
      c1_wr_request = 1'b1;
      @(negedge clk);
      chk("mrst_nodone", 64'({c0_wr_done, c1_wr_done}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_nodone2", 64'({c0_wr_done, c1_wr_done}), 64'd0);
      chk("mrst_grant1", 64'(grant), 64'd1);
      chk("mrst_req1", 64'(ram_wr_request), 64'd1);
      chk("mrst_data1", 64'(ram_wr_data), 64'hBEEFCAFE);
      ram_wr_done = 1'b1;
      @(negedge clk);
      ram_wr_done = 1'b0;
      chk("mrst_done1", 64'({c1_wr_done, c0_wr_done}), 64'd2);
      @(negedge clk);
      drop_all();
      @(negedge clk);
      chk("final_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
